// File: rtl/sfifo_gpio_if.sv
// sfifo_gpio_if
//   WISHBONE slave for the motion core. It drains a first-word-fall-through
//   sync FIFO through the DI register, counts base-period ticks, issues
//   indexed DOUT set/reset pulses and captures DIN rising edges with an IRQ.
//   A DI read stalls while the FIFO is empty. If the FIFO stays empty for
//   TO_CYC clocks, the read ends with wb_err_o.
//
// Ports
//   wb_clk_i, wb_rst_n_i   clock, asynchronous active-low reset
//   wb_cyc_i/stb_i/we_i    bus cycle, strobe, write enable
//   wb_sel_i[3:0]          byte selects (sel[3] = bits 31:24)
//   wb_adr_i[WB_AW-1:2]    word address, register select on [4:2]
//   wb_dat_i / wb_dat_o    write data / registered read data
//   wb_ack_o, wb_err_o     acknowledge / DI timeout error
//   sfifo_rd_o             FIFO pop pulse
//   sfifo_empty_i, sfifo_di FIFO empty flag and FWFT head word
//   sfifo_bp_tick_i        asynchronous base-period tick
//   dout_set_o/dout_rst_o  one-cycle indexed set/reset pulses
//   din_i                  asynchronous raw inputs
//   irq_o                  level interrupt
//
// Register map (word offset):
//   0 BP_TICK   RO count, any write clears
//   1 STATUS    b0 empty (RO), b1 timeout sticky (W1C), b2 IRQ_EN (RW)
//   2 DI        RO {head, 0...}, each read pops
//   3 DOUT_CMD  WO {en, val, idx[5:0]} in bits 31:24, needs sel[3]
//   4 DIN       RO synchronised inputs
//   5 DIN_EDGE  rising-edge sticky bits, W1C
//   6 DIN_IEN   RW edge mask
//   7           reserved
module sfifo_gpio_if #(
    parameter int unsigned WB_AW    = 6,
    parameter int unsigned WB_DW    = 32,
    parameter int unsigned SFIFO_DW = 16,
    parameter int unsigned DOUT_W   = 16,
    parameter int unsigned DIN_W    = 16,
    parameter int unsigned TO_CYC   = 1024
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [3:0]          wb_sel_i,
    input  logic [WB_AW-1:2]    wb_adr_i,
    input  logic [WB_DW-1:0]    wb_dat_i,
    output logic [WB_DW-1:0]    wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                sfifo_rd_o,
    input  logic                sfifo_empty_i,
    input  logic [SFIFO_DW-1:0] sfifo_di,
    input  logic                sfifo_bp_tick_i,
    output logic [DOUT_W-1:0]   dout_set_o,
    output logic [DOUT_W-1:0]   dout_rst_o,
    input  logic [DIN_W-1:0]    din_i,
    output logic                irq_o
);

    generate
        if (DOUT_W < 1 || DOUT_W > 64) begin : g_bad_dout_w
            $error("sfifo_gpio_if: DOUT_W must be in 1..64");
        end
        if (DIN_W < 1 || DIN_W > 32) begin : g_bad_din_w
            $error("sfifo_gpio_if: DIN_W must be in 1..32");
        end
        if (SFIFO_DW < 1 || SFIFO_DW > 32) begin : g_bad_sfifo_dw
            $error("sfifo_gpio_if: SFIFO_DW must be in 1..32");
        end
        if (WB_DW != 32) begin : g_bad_wb_dw
            $error("sfifo_gpio_if: WB_DW must be 32 (four byte selects)");
        end
        if (WB_AW < 5) begin : g_bad_wb_aw
            $error("sfifo_gpio_if: WB_AW must be at least 5");
        end
    endgenerate

    typedef enum logic [2:0] {
        REG_BP_TICK  = 3'd0,
        REG_STATUS   = 3'd1,
        REG_DI       = 3'd2,
        REG_DOUT_CMD = 3'd3,
        REG_DIN      = 3'd4,
        REG_DIN_EDGE = 3'd5,
        REG_DIN_IEN  = 3'd6,
        REG_RSVD     = 3'd7
    } reg_e;

    // The wait counter only has to reach TO_CYC-1; the error is issued on that cycle.
    localparam int unsigned    TO_W    = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TO_CYC > 0) ? TO_CYC - 1 : 0);

    reg_e               reg_sel;
    logic               req, wr, di_rd, di_wait, to_hit;
    logic [TO_W-1:0]    to_cnt;
    logic [WB_DW-1:0]   rdata;
    logic [31:0]        wmask;

    logic               to_sticky, irq_en, status_wr;

    logic [2:0]         bp_sync;
    logic               bp_rise, bp_clr;
    logic [31:0]        bp_cnt;

    logic [DIN_W-1:0]   din_s1, din_s2, din_s3;
    logic [DIN_W-1:0]   din_rise, din_edge, din_ien, edge_clr, ien_mask;
    logic               ien_wr;

    logic [7:0]         cmd_byte;
    logic               cmd_ok;
    logic [DOUT_W-1:0]  cmd_hot;

    logic               unused_ok;

    assign reg_sel = reg_e'(wb_adr_i[4:2]);

    // A request is not taken in the cycle its own ack/err is shown, so a
    // master that holds stb through that edge never gets two responses.
    assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign wr      = req & wb_we_i;
    assign di_rd   = req & ~wb_we_i & (reg_sel == REG_DI);
    assign di_wait = di_rd & sfifo_empty_i;
    assign to_hit  = di_wait & (TO_CYC != 0) & (to_cnt == TO_LAST);

    assign wmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    assign status_wr = wr & (reg_sel == REG_STATUS) & wb_sel_i[0];
    assign bp_clr    = wr & (reg_sel == REG_BP_TICK);
    assign ien_wr    = wr & (reg_sel == REG_DIN_IEN);
    assign ien_mask  = wmask[DIN_W-1:0];
    assign edge_clr  = (wr && reg_sel == REG_DIN_EDGE) ? (wb_dat_i[DIN_W-1:0] & ien_mask) : '0;

    // bp_sync[1:0] is the two-flop synchroniser; bp_sync[2] is the previous
    // synchronised value for the edge detector. The DIN chain uses the same layout.
    assign bp_rise  = bp_sync[1] & ~bp_sync[2];
    assign din_rise = din_s2 & ~din_s3;

    assign cmd_byte = wb_dat_i[31:24];
    assign cmd_ok   = wr & (reg_sel == REG_DOUT_CMD) & wb_sel_i[3] & cmd_byte[7]
                    & ({1'b0, cmd_byte[5:0]} < 7'(DOUT_W));

    always_comb begin
        cmd_hot = '0;
        for (int unsigned i = 0; i < DOUT_W; i++) begin
            cmd_hot[i] = (cmd_byte[5:0] == 6'(i));
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_BP_TICK:  rdata = bp_cnt;
            REG_STATUS:   begin
                rdata[0] = sfifo_empty_i;
                rdata[1] = to_sticky;
                rdata[2] = irq_en;
            end
            REG_DI:       rdata[WB_DW-1 -: SFIFO_DW] = sfifo_di;
            REG_DIN:      rdata[DIN_W-1:0] = din_s2;
            REG_DIN_EDGE: rdata[DIN_W-1:0] = din_edge;
            REG_DIN_IEN:  rdata[DIN_W-1:0] = din_ien;
            default:      rdata = '0;
        endcase
    end

    // Bus response, FIFO pop and DI empty-wait timeout.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wb_ack_o   <= 1'b0;
            wb_err_o   <= 1'b0;
            sfifo_rd_o <= 1'b0;
            wb_dat_o   <= '0;
            to_cnt     <= '0;
        end else begin
            wb_ack_o   <= req & ~di_wait;
            wb_err_o   <= to_hit;
            sfifo_rd_o <= di_rd & ~sfifo_empty_i;
            wb_dat_o   <= (req && !wb_we_i && !di_wait) ? rdata : '0;
            if (di_wait && TO_CYC != 0) begin
                to_cnt <= to_hit ? '0 : to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // STATUS bits and the base-period tick counter.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            to_sticky <= 1'b0;
            irq_en    <= 1'b0;
            bp_sync   <= '0;
            bp_cnt    <= '0;
        end else begin
            if (to_hit) begin
                to_sticky <= 1'b1;
            end else if (status_wr && wb_dat_i[1]) begin
                to_sticky <= 1'b0;
            end
            if (status_wr) begin
                irq_en <= wb_dat_i[2];
            end
            bp_sync <= {bp_sync[1:0], sfifo_bp_tick_i};
            // A clear coinciding with an edge still counts that edge.
            if (bp_clr) begin
                bp_cnt <= {31'd0, bp_rise};
            end else if (bp_rise) begin
                bp_cnt <= bp_cnt + 32'd1;
            end
        end
    end

    // DIN capture, edge stickies, mask, IRQ and DOUT pulses.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            din_s1     <= '0;
            din_s2     <= '0;
            din_s3     <= '0;
            din_edge   <= '0;
            din_ien    <= '0;
            irq_o      <= 1'b0;
            dout_set_o <= '0;
            dout_rst_o <= '0;
        end else begin
            din_s1   <= din_i;
            din_s2   <= din_s1;
            din_s3   <= din_s2;
            // New edges win over a W1C to the same bit.
            din_edge <= (din_edge & ~edge_clr) | din_rise;
            if (ien_wr) begin
                din_ien <= (din_ien & ~ien_mask) | (wb_dat_i[DIN_W-1:0] & ien_mask);
            end
            irq_o      <= irq_en & (|(din_edge & din_ien));
            dout_set_o <= (cmd_ok &&  cmd_byte[6]) ? cmd_hot : '0;
            dout_rst_o <= (cmd_ok && !cmd_byte[6]) ? cmd_hot : '0;
        end
    end

    assign unused_ok = ^{wb_dat_i, wb_adr_i};

endmodule

// File: tb/tb_sfifo_gpio_if.sv
module tb_sfifo_gpio_if;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [5:2]  adr;
    logic [31:0] wdat;
    logic [31:0] dat_o;
    logic        ack, err, rd;
    logic        empty;
    logic [15:0] fdi;
    logic        bp;
    logic [15:0] dset, drst;
    logic [15:0] din;
    logic        irq;

    always #5 clk = ~clk;

    sfifo_gpio_if #(
        .WB_AW(6), .WB_DW(32), .SFIFO_DW(16), .DOUT_W(16), .DIN_W(16), .TO_CYC(TO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
        .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_o),
        .wb_ack_o(ack), .wb_err_o(err), .sfifo_rd_o(rd),
        .sfifo_empty_i(empty), .sfifo_di(fdi), .sfifo_bp_tick_i(bp),
        .dout_set_o(dset), .dout_rst_o(drst), .din_i(din), .irq_o(irq)
    );

    int unsigned n_vec = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO environment
    logic [15:0] fq[$];
    int unsigned n_pops = 0;
    logic        rnd_async = 1'b0;

    task automatic fifo_pins();
        empty = (fq.size() == 0);
        fdi   = empty ? 16'h0 : fq[0];
    endtask

    // Behavioural model: expected outputs after the next clock edge.
    logic        chk_en = 1'b0;
    logic        e_ack = 0, e_err = 0, e_rd = 0, e_rdv = 0, e_irq = 0;
    logic [31:0] e_dat = '0;
    logic [15:0] e_set = '0, e_rst = '0;

    logic        m_ack, m_err, m_sticky, m_irqen;
    int unsigned m_wcnt;
    logic [31:0] m_bp;
    logic [15:0] m_edge, m_ien;
    logic [3:1]  bh;                // raw bp at 1/2/3 edges ago
    logic [15:0] dh1, dh2, dh3;     // raw din at 1/2/3 edges ago

    task automatic model_reset();
        m_ack = 0; m_err = 0; m_sticky = 0; m_irqen = 0; m_wcnt = 0;
        m_bp = '0; m_edge = '0; m_ien = '0; bh = '0;
        dh1 = '0; dh2 = '0; dh3 = '0;
        e_ack = 0; e_err = 0; e_rd = 0; e_rdv = 0; e_irq = 0;
        e_dat = '0; e_set = '0; e_rst = '0;
    endtask

    task automatic model_eval();
        logic        req, bpe;
        logic [15:0] de, m, nedge;
        logic [31:0] wm, nbp;
        logic [7:0]  cb;
        req = cyc & stb & ~m_ack & ~m_err;
        bpe = bh[2] & ~bh[3];
        de  = dh2 & ~dh3;
        wm  = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        m   = wm[15:0];
        e_ack = 0; e_err = 0; e_rd = 0; e_rdv = 0; e_dat = '0; e_set = '0; e_rst = '0;
        e_irq = m_irqen & (|(m_edge & m_ien));
        nbp   = m_bp + {31'd0, bpe};
        nedge = m_edge | de;
        if (req && !we && adr[4:2] == 3'd2 && empty) begin
            m_wcnt++;
            if (m_wcnt == TO) begin
                e_err = 1; m_sticky = 1; m_wcnt = 0;
            end
        end else begin
            m_wcnt = 0;
            if (req && !we) begin
                e_ack = 1; e_rdv = 1;
                case (adr[4:2])
                    3'd0: e_dat = m_bp;
                    3'd1: e_dat = {29'd0, m_irqen, m_sticky, empty};
                    3'd2: begin e_dat = {fdi, 16'h0}; e_rd = 1; end
                    3'd4: e_dat = {16'h0, dh2};
                    3'd5: e_dat = {16'h0, m_edge};
                    3'd6: e_dat = {16'h0, m_ien};
                    default: e_dat = '0;
                endcase
            end else if (req) begin
                e_ack = 1;
                case (adr[4:2])
                    3'd0: nbp = {31'd0, bpe};
                    3'd1: if (sel[0]) begin
                              if (wdat[1]) m_sticky = 0;
                              m_irqen = wdat[2];
                          end
                    3'd3: begin
                              cb = wdat[31:24];
                              if (sel[3] && cb[7] && cb[5:0] < 6'd16) begin
                                  if (cb[6]) e_set = 16'd1 << cb[5:0];
                                  else       e_rst = 16'd1 << cb[5:0];
                              end
                          end
                    3'd5: nedge = (m_edge & ~(wdat[15:0] & m)) | de;
                    3'd6: m_ien = (m_ien & ~m) | (wdat[15:0] & m);
                    default: ;
                endcase
            end
        end
        m_bp = nbp; m_edge = nedge; m_ack = e_ack; m_err = e_err;
        bh  = {bh[2:1], bp};
        dh3 = dh2; dh2 = dh1; dh1 = din;
    endtask

    // One clock: called at a falling edge with inputs set, returns at the next falling edge.
    task automatic step();
        if (rnd_async) begin
            bp  = 1'($urandom_range(0, 1));
            din = 16'($urandom);
        end
        model_eval();
        @(posedge clk);
        @(negedge clk);
        if (rd) begin
            n_pops++;
            if (fq.size() > 0) void'(fq.pop_front());
        end
        if (rnd_async && fq.size() < 8 && $urandom_range(0, 3) == 0) fq.push_back(16'($urandom));
        fifo_pins();
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("ack",   ack,  e_ack);
            chk("err",   err,  e_err);
            chk("rd",    rd,   e_rd);
            chk("set",   dset, e_set);
            chk("rst",   drst, e_rst);
            chk("irq",   irq,  e_irq);
            if (e_rdv) chk("rdata", dat_o, e_dat);
            if (e_err) chk("err_data", dat_o, 32'h0);
        end
    end

    logic [15:0] last_set, last_rst;

    task automatic wb_xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int unsigned push_at,
                           input logic [15:0] push_val, output logic [31:0] rdat,
                           output logic gack, output logic gerr, output int unsigned ncyc);
        cyc = 1; stb = 1; we = w; adr = {1'b0, a}; wdat = d; sel = s;
        ncyc = 0; gack = 0; gerr = 0; rdat = '0;
        while (1) begin
            step();
            ncyc++;
            if (ack || err) begin
                gack = ack; gerr = err; rdat = dat_o; last_set = dset; last_rst = drst;
                break;
            end
            if (push_at != 0 && ncyc == push_at) begin
                fq.push_back(push_val);
                fifo_pins();
            end
            if (ncyc >= 40) begin
                chk("bus_response", 1'b0, 1'b1);
                break;
            end
        end
        if ($urandom_range(0, 1) == 1) step();   // master holds stb through the response edge
        cyc = 0; stb = 0; we = 0; wdat = '0; sel = '0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] v);
        logic ga, ge; int unsigned n;
        wb_xfer(0, a, 32'h0, 4'hF, 0, 16'h0, v, ga, ge, n);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v; logic ga, ge; int unsigned n;
        wb_xfer(1, a, d, s, 0, 16'h0, v, ga, ge, n);
    endtask

    initial begin
        logic [31:0] v;
        logic        ga, ge;
        int unsigned n, p0;

        rst_n = 0; cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; wdat = '0;
        bp = 0; din = '0; last_set = '0; last_rst = '0;
        fifo_pins();
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_ack", ack, 1'b0);
        chk("reset_err", err, 1'b0);
        chk("reset_rd",  rd,  1'b0);
        chk("reset_dat", dat_o, 32'h0);
        chk("reset_irq", irq, 1'b0);
        chk("reset_set", dset, 16'h0);
        rst_n = 1;
        model_reset();
        chk_en = 1;

        // FIFO drain
        fq.push_back(16'h1234); fq.push_back(16'hBEEF); fifo_pins();
        p0 = n_pops;
        rd_reg(3'd2, v); chk("di_first",  v, 32'h12340000);
        rd_reg(3'd2, v); chk("di_second", v, 32'hBEEF0000);
        chk("di_pops", n_pops - p0, 2);
        rd_reg(3'd1, v); chk("status_empty", v, 32'h1);

        // Timeout on empty FIFO
        p0 = n_pops;
        wb_xfer(0, 3'd2, 32'h0, 4'hF, 0, 16'h0, v, ga, ge, n);
        chk("to_err", ge, 1'b1);
        chk("to_noack", ga, 1'b0);
        chk("to_cycle", n + 1, 9);
        chk("to_data", v, 32'h0);
        chk("to_nopop", n_pops - p0, 0);
        rd_reg(3'd1, v); chk("status_to", v, 32'h3);
        wr_reg(3'd1, 32'h2, 4'hF);
        rd_reg(3'd1, v); chk("status_w1c", v, 32'h1);

        // FIFO fills during the wait
        p0 = n_pops;
        wb_xfer(0, 3'd2, 32'h0, 4'hF, 3, 16'hA5A5, v, ga, ge, n);
        chk("late_ack", ga, 1'b1);
        chk("late_noerr", ge, 1'b0);
        chk("late_data", v, 32'hA5A50000);
        chk("late_cycles", n, 4);
        chk("late_pops", n_pops - p0, 1);

        // Base-period ticks
        wr_reg(3'd0, 32'h0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            bp = 1; repeat (3) step();
            bp = 0; repeat (3) step();
        end
        repeat (3) step();
        rd_reg(3'd0, v); chk("bp_five", v, 32'd5);
        bp = 1; step(); step();
        wr_reg(3'd0, 32'h0, 4'hF);          // clear lands on the edge
        bp = 0;
        repeat (3) step();
        rd_reg(3'd0, v); chk("bp_clr_edge", v, 32'd1);

        // DOUT commands
        wr_reg(3'd3, 32'hC3000000, 4'hF); chk("dout_set3", last_set, 16'h0008); chk("dout_set3_r", last_rst, 16'h0);
        wr_reg(3'd3, 32'h83000000, 4'hF); chk("dout_rst3", last_rst, 16'h0008); chk("dout_rst3_s", last_set, 16'h0);
        wr_reg(3'd3, 32'h43000000, 4'hF); chk("dout_en0", last_set | last_rst, 16'h0);
        wr_reg(3'd3, 32'hD4000000, 4'hF); chk("dout_idx20", last_set | last_rst, 16'h0);
        wr_reg(3'd3, 32'hC3000000, 4'h7); chk("dout_nosel", last_set | last_rst, 16'h0);
        wr_reg(3'd3, 32'hCF000000, 4'h8); chk("dout_set15", last_set, 16'h8000);

        // DIN edge + IRQ
        wr_reg(3'd6, 32'h4, 4'hF);
        wr_reg(3'd1, 32'h4, 4'hF);
        din = 16'h0004;
        repeat (5) step();
        chk("irq_on", irq, 1'b1);
        rd_reg(3'd5, v); chk("din_edge", v, 32'h4);
        rd_reg(3'd4, v); chk("din_sync", v, 32'h4);
        wr_reg(3'd5, 32'h4, 4'hF);
        repeat (2) step();
        chk("irq_off", irq, 1'b0);

        // Randomized traffic
        rnd_async = 1;
        for (int t = 0; t < 300; t++) begin
            logic [3:0] s;
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            wb_xfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, s,
                    0, 16'h0, v, ga, ge, n);
            repeat ($urandom_range(0, 2)) step();
        end
        rnd_async = 0;

        // Reset in the middle of a DI wait
        fq.delete(); fifo_pins();
        din = '0; bp = 0;
        repeat (4) step();
        wr_reg(3'd6, 32'hFFFF, 4'hF);
        wr_reg(3'd1, 32'h4, 4'hF);
        din = 16'h0001;
        repeat (5) step();
        chk("pre_reset_irq", irq, 1'b1);
        cyc = 1; stb = 1; we = 0; adr = 4'd2; sel = 4'hF;
        repeat (3) step();
        #2;
        chk_en = 0;
        rst_n = 0;
        #1;
        chk("mid_reset_ack", ack, 1'b0);
        chk("mid_reset_err", err, 1'b0);
        chk("mid_reset_rd",  rd,  1'b0);
        chk("mid_reset_dat", dat_o, 32'h0);
        chk("mid_reset_irq", irq, 1'b0);
        chk("mid_reset_dout", {dset, drst}, 32'h0);
        @(negedge clk);
        cyc = 0; stb = 0; din = '0;
        rst_n = 1;
        model_reset();
        chk_en = 1;
        repeat (12) step();
        rd_reg(3'd1, v); chk("post_reset_status", v, 32'h1);
        rd_reg(3'd6, v); chk("post_reset_ien", v, 32'h0);
        repeat (2) step();

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
